// File: rtl/bram_preload_ctrl_if.sv
// Host-side bundle for bram_preload_ctrl: burst command, write-data stream and read-data stream.
// The controller attaches through the slave modport; the host side uses master.
interface bram_preload_ctrl_if #(
    parameter int unsigned COL_W  = 10,
    parameter int unsigned ROW_W  = 22,
    parameter int unsigned DATA_W = 36,
    parameter int unsigned LEN_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [1:0]        cmd_wen;
    logic [COL_W-1:0]  cmd_col;
    logic [ROW_W-1:0]  cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output cmd_valid, cmd_write, cmd_wen, cmd_col, cmd_addr, cmd_len,
        output wdata_valid, wdata, rdata_ready,
        input  cmd_ready, wdata_ready, rdata_valid, rdata
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_wen, cmd_col, cmd_addr, cmd_len,
        input  wdata_valid, wdata, rdata_ready,
        output cmd_ready, wdata_ready, rdata_valid, rdata
    );
endinterface

// File: rtl/bram_preload_ctrl.sv
// BRAM preload bus initiator: burst commands plus a write stream become strobed PL accesses.
// Define BRAM_PL_VERIFY_EN to read back and compare every written word (sticky err_o).
module bram_preload_ctrl #(
    parameter int unsigned COL_W  = 10,
    parameter int unsigned ROW_W  = 22,
    parameter int unsigned DATA_W = 36,
    parameter int unsigned LEN_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    bram_preload_ctrl_if.slave host_io,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               pl_init_o,
    output logic               pl_ena_o,
    output logic               pl_ren_o,
    output logic               pl_clk_o,
    output logic [1:0]         pl_wen_o,
    output logic [31:0]        pl_addr_o,
    output logic [DATA_W-1:0]  pl_data_o,
    input  logic [DATA_W-1:0]  pl_data_i
);

    typedef enum logic [3:0] {
        StIdle, StSetup, StStrobe, StCapture, StRhold, StNext, StDone,
        StVSetup, StVStrobe, StVCapture
    } state_e;

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               write_q, write_d;
    logic [1:0]         wen_q, wen_d;
    logic               busy_q, busy_d, done_q, done_d, init_q, init_d;
    logic               ena_q, ena_d, ren_q, ren_d, pclk_q, pclk_d;
    logic [1:0]         pwen_q, pwen_d;
    logic [31:0]        addr_q, addr_d;
    logic [DATA_W-1:0]  pdata_q, pdata_d, rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               wready, advance;

`ifdef BRAM_PL_VERIFY_EN
    localparam int unsigned HalfW = DATA_W / 2;
    logic              err_q, err_d;
    logic [DATA_W-1:0] vmask;
    assign vmask = {{(DATA_W - HalfW){wen_q[1]}}, {HalfW{wen_q[0]}}};
`endif

    always_comb begin
        state_d = state_q;  col_d = col_q;    row_d = row_q;     rem_d = rem_q;
        write_d = write_q;  wen_d = wen_q;    busy_d = busy_q;   init_d = init_q;
        ena_d = ena_q;      ren_d = ren_q;    pwen_d = pwen_q;   addr_d = addr_q;
        pdata_d = pdata_q;  rdata_d = rdata_q; rvalid_d = rvalid_q;
        done_d = 1'b0;      pclk_d = 1'b0;    wready = 1'b0;     advance = 1'b0;
`ifdef BRAM_PL_VERIFY_EN
        err_d = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (host_io.cmd_valid) begin
                    col_d   = host_io.cmd_col;
                    row_d   = host_io.cmd_addr;
                    rem_d   = host_io.cmd_len;
                    write_d = host_io.cmd_write;
                    wen_d   = host_io.cmd_wen;
                    addr_d  = {host_io.cmd_col, host_io.cmd_addr};
                    busy_d  = 1'b1;
                    init_d  = 1'b1;
                    ena_d   = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (!write_q) begin
                    ren_d   = 1'b1;
                    pwen_d  = 2'b00;
                    pclk_d  = 1'b1;
                    state_d = StStrobe;
                end else if (host_io.wdata_valid) begin
                    // One stream word per access: ready only in the cycle it is consumed.
                    wready  = 1'b1;
                    pdata_d = host_io.wdata;
                    pwen_d  = wen_q;
                    ren_d   = 1'b0;
                    pclk_d  = 1'b1;
                    state_d = StStrobe;
                end
            end
            StStrobe: begin
                if (!write_q) begin
                    state_d = StCapture;
                end else begin
`ifdef BRAM_PL_VERIFY_EN
                    ren_d   = 1'b1;
                    pwen_d  = 2'b00;
                    state_d = StVSetup;
`else
                    state_d = StNext;
`endif
                end
            end
            StCapture: begin
                rdata_d  = pl_data_i;
                rvalid_d = 1'b1;
                ena_d    = 1'b0;
                ren_d    = 1'b0;
                state_d  = StRhold;
            end
            StRhold: begin
                if (host_io.rdata_ready) begin
                    rvalid_d = 1'b0;
                    advance  = 1'b1;
                end
            end
            StNext: advance = 1'b1;
            StDone: state_d = StIdle;
`ifdef BRAM_PL_VERIFY_EN
            StVSetup: begin
                pclk_d  = 1'b1;
                state_d = StVStrobe;
            end
            StVStrobe: state_d = StVCapture;
            StVCapture: begin
                if (((pl_data_i ^ pdata_q) & vmask) != '0) err_d = 1'b1;
                ren_d   = 1'b0;
                state_d = StNext;
            end
`endif
            default: state_d = StIdle;
        endcase

        // Shared word-advance step, reached from NEXT or directly from an accepted read.
        if (advance) begin
            pwen_d = 2'b00;
            ren_d  = 1'b0;
            if (rem_q == '0) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                init_d  = 1'b0;
                ena_d   = 1'b0;
                addr_d  = '0;
                pdata_d = '0;
                state_d = StDone;
            end else begin
                rem_d   = rem_q - LEN_W'(1);
                row_d   = row_q + ROW_W'(1);
                addr_d  = {col_q, row_d};
                ena_d   = 1'b1;
                state_d = StSetup;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;  col_q <= '0;    row_q <= '0;    rem_q <= '0;
            write_q <= 1'b0;    wen_q <= '0;    busy_q <= 1'b0; done_q <= 1'b0;
            init_q <= 1'b0;     ena_q <= 1'b0;  ren_q <= 1'b0;  pclk_q <= 1'b0;
            pwen_q <= '0;       addr_q <= '0;   pdata_q <= '0;  rdata_q <= '0;
            rvalid_q <= 1'b0;
`ifdef BRAM_PL_VERIFY_EN
            err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d; col_q <= col_d; row_q <= row_d; rem_q <= rem_d;
            write_q <= write_d; wen_q <= wen_d; busy_q <= busy_d; done_q <= done_d;
            init_q <= init_d;   ena_q <= ena_d; ren_q <= ren_d; pclk_q <= pclk_d;
            pwen_q <= pwen_d;   addr_q <= addr_d; pdata_q <= pdata_d; rdata_q <= rdata_d;
            rvalid_q <= rvalid_d;
`ifdef BRAM_PL_VERIFY_EN
            err_q <= err_d;
`endif
        end
    end

`ifdef BRAM_PL_VERIFY_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign host_io.cmd_ready   = (state_q == StIdle);
    assign host_io.wdata_ready = wready;
    assign host_io.rdata_valid = rvalid_q;
    assign host_io.rdata       = rdata_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pl_init_o = init_q;
    assign pl_ena_o  = ena_q;
    assign pl_ren_o  = ren_q;
    assign pl_clk_o  = pclk_q;
    assign pl_wen_o  = pwen_q;
    assign pl_addr_o = addr_q;
    assign pl_data_o = pdata_q;

endmodule

// File: tb/tb_bram_preload_ctrl.sv
// Self-checking bench for bram_preload_ctrl: a BRAM column shim plus a command-level memory model.
module tb_bram_preload_ctrl;
    localparam int unsigned COL_W = 10, ROW_W = 22, DATA_W = 36, LEN_W = 16;
`ifdef BRAM_PL_VERIFY_EN
    localparam int PPW = 2;
`else
    localparam int PPW = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic busy, done, err, pl_init, pl_ena, pl_ren, pl_clk;
    logic [1:0] pl_wen;
    logic [31:0] pl_addr;
    logic [35:0] pl_data_o, pl_di;

    bram_preload_ctrl_if #(.COL_W(COL_W), .ROW_W(ROW_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) host ();

    bram_preload_ctrl #(.COL_W(COL_W), .ROW_W(ROW_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_i(rst), .host_io(host.slave),
        .busy_o(busy), .done_o(done), .err_o(err),
        .pl_init_o(pl_init), .pl_ena_o(pl_ena), .pl_ren_o(pl_ren), .pl_clk_o(pl_clk),
        .pl_wen_o(pl_wen), .pl_addr_o(pl_addr), .pl_data_o(pl_data_o), .pl_data_i(pl_di)
    );

    int n_total = 0, n_bad = 0;
    int pulse_cnt = 0, done_cnt = 0, dbl_cnt = 0, noena_cnt = 0;
    logic pclk_prev = 1'b0;
    logic [31:0] acc_addr [256];
    logic [35:0] acc_data [256];
    logic [1:0]  acc_wen  [256];
    logic [35:0] shim_mem [1024];
    bit          shim_wr  [1024];
    logic [35:0] ref_mem  [1024];
    bit          ref_wr   [1024];
    logic [35:0] wq [$];
    bit          corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Small memory window: low 5 bits of column and row.
    function automatic logic [9:0] midx(input logic [31:0] a);
        return {a[26:22], a[4:0]};
    endfunction
    function automatic logic [35:0] dflt(input logic [31:0] a);
        return ~{4'h0, a};
    endfunction
    function automatic logic [35:0] merge(input logic [35:0] old, input logic [35:0] nw,
                                          input logic [1:0] wen);
        return {wen[1] ? nw[35:18] : old[35:18], wen[0] ? nw[17:0] : old[17:0]};
    endfunction
    function automatic logic [35:0] shim_rd(input logic [31:0] a);
        return shim_wr[midx(a)] ? shim_mem[midx(a)] : dflt(a);
    endfunction
    function automatic logic [35:0] ref_rd(input logic [31:0] a);
        return ref_wr[midx(a)] ? ref_mem[midx(a)] : dflt(a);
    endfunction

    // Column shim: acts on each pl_clk_o strobe, logs every access.
    always @(posedge clk) begin
        pclk_prev <= pl_clk;
        if (done) done_cnt <= done_cnt + 1;
        if (pl_clk) begin
            acc_addr[pulse_cnt[7:0]] <= pl_addr;
            acc_data[pulse_cnt[7:0]] <= pl_data_o;
            acc_wen[pulse_cnt[7:0]]  <= pl_wen;
            pulse_cnt <= pulse_cnt + 1;
            if (pclk_prev) dbl_cnt <= dbl_cnt + 1;
            if (!pl_ena) noena_cnt <= noena_cnt + 1;
            if (pl_wen != 2'b00) begin
                shim_mem[midx(pl_addr)] <= merge(shim_rd(pl_addr), pl_data_o ^
                    ((corrupt_en && pl_addr == corrupt_addr) ? 36'h0_0010_0000 : 36'h0), pl_wen);
                shim_wr[midx(pl_addr)] <= 1'b1;
            end
            if (pl_ren) pl_di <= shim_rd(pl_addr);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_pl"}, 64'({pl_init, pl_ena, pl_ren, pl_clk, pl_wen, pl_addr, pl_data_o}), 64'h0);
        check_eq({tag, "_st"}, 64'({host.cmd_ready, busy, done, host.rdata_valid, host.wdata_ready}),
                 64'b10000);
    endtask

    // Issues one command and runs it to done_o (or aborts with rst at a given strobe index).
    task automatic run_cmd(input bit wr, input logic [9:0] col, input logic [21:0] row,
                           input int len, input logic [1:0] wen, input int gap, input int bp,
                           input int abort_at, input bit noise);
        int words, base, dbase, wi, ri, cyc, nwr;
        bit fin, aborted, took;
        logic [35:0] exp_rd [$];
        logic [21:0] r;
        logic [31:0] a;
        words = len + 1; base = pulse_cnt; dbase = done_cnt;
        wi = 0; ri = 0; cyc = 0; fin = 0; aborted = 0; nwr = words;
        for (int i = 0; i < words; i++) begin
            r = row + 22'(i);
            exp_rd.push_back(ref_rd({col, r}));
        end
        host.cmd_write = wr; host.cmd_wen = wen; host.cmd_col = col;
        host.cmd_addr = row; host.cmd_len = 16'(len); host.cmd_valid = 1'b1;
        check_eq("cmd_ready", 64'(host.cmd_ready), 64'd1);
        step();
        host.cmd_valid = 1'b0;
        check_eq("burst_start", 64'({pl_init, busy, host.cmd_ready}), 64'b110);
        host.wdata_valid = wr && ($urandom_range(0, gap) == 0);
        host.wdata = wq[0];
        host.rdata_ready = ($urandom_range(0, bp) == 0);
        while (!fin && !aborted && cyc < 500) begin
            if (abort_at >= 0 && pl_clk && (pulse_cnt - base) == abort_at) begin
                rst = 1'b1; #1;
                check_idle("abort");
                @(negedge clk); rst = 1'b0;
                aborted = 1; nwr = abort_at / PPW;
            end else begin
                @(negedge clk);
                took = host.wdata_valid && host.wdata_ready;
                if (took) wi++;
                if (host.rdata_valid && host.rdata_ready) begin
                    check_eq("rdata", 64'(host.rdata), 64'(exp_rd[ri]));
                    ri++;
                end
                if (done) begin
                    fin = 1; host.cmd_valid = 1'b0;
                    check_eq("done_drop", 64'({busy, pl_init, pl_ena}), 64'd0);
                end
                step(); cyc++;
                if (took || !host.wdata_valid) begin
                    host.wdata_valid = wr && (wi < words) && ($urandom_range(0, gap) == 0);
                    if (wi < words) host.wdata = wq[wi];
                end
                host.rdata_ready = ($urandom_range(0, bp) == 0);
                if (noise && !fin) begin
                    host.cmd_valid = 1'($urandom_range(0, 1));
                    host.cmd_col = 10'($urandom); host.cmd_addr = 22'($urandom);
                    host.cmd_write = 1'($urandom);
                end
            end
        end
        host.wdata_valid = 1'b0; host.rdata_ready = 1'b0; host.cmd_valid = 1'b0;
        if (!aborted) begin
            check_eq("done_seen", 64'(fin), 64'd1);
            check_eq("done_once", 64'(done_cnt - dbase), 64'd1);
            check_eq("words", 64'(wr ? wi : ri), 64'(words));
            check_eq("pulses", 64'(pulse_cnt - base), 64'(words * (wr ? PPW : 1)));
            for (int i = 0; i < words; i++) begin
                r = row + 22'(i);
                check_eq("pl_addr", 64'(acc_addr[8'(base + i * (wr ? PPW : 1))]), 64'({col, r}));
                if (wr) check_eq("pl_wdata", 64'({acc_wen[8'(base + i * PPW)],
                                 acc_data[8'(base + i * PPW)]}), 64'({wen, wq[i]}));
            end
        end
        if (wr && wen != 2'b00) begin
            for (int i = 0; i < nwr; i++) begin
                r = row + 22'(i);
                a = {col, r};
                ref_mem[midx(a)] = merge(ref_rd(a), wq[i], wen);
                ref_wr[midx(a)] = 1'b1;
            end
        end
    endtask

    initial begin
        logic [35:0] v;
        int p, cnt, d0;
        bit ok;
        host.cmd_valid = 0; host.cmd_write = 0; host.cmd_wen = 0; host.cmd_col = 0;
        host.cmd_addr = 0; host.cmd_len = 0; host.wdata_valid = 0; host.wdata = 0;
        host.rdata_ready = 0; pl_di = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        step();
        check_idle("reset");
        check_eq("reset_err", 64'(err), 64'd0);

        // Directed write: col 19, rows 0..3, data 0..3.
        wq = {36'd0, 36'd1, 36'd2, 36'd3};
        p = pulse_cnt;
        run_cmd(1'b1, 10'd19, 22'd0, 3, 2'b11, 0, 0, -1, 1'b0);
        check_eq("wr_first_addr", 64'(acc_addr[8'(p)]), 64'h04C0_0000);
        check_eq("wr_last_addr", 64'(acc_addr[8'(p + 3 * PPW)]), 64'h04C0_0003);
        step();
        check_idle("after_wr");

        // Directed read: col 67 from row 5, two words of the shim default pattern.
        run_cmd(1'b0, 10'd67, 22'd5, 1, 2'b00, 0, 0, -1, 1'b0);

        // Backpressure: rdata held 10 cycles, no further strobes until accepted.
        host.cmd_write = 0; host.cmd_col = 10'd28; host.cmd_addr = 22'd2; host.cmd_len = 16'd1;
        host.cmd_valid = 1; d0 = done_cnt;
        step(); host.cmd_valid = 0;
        cnt = 0;
        while (!host.rdata_valid && cnt < 50) begin step(); cnt++; end
        check_eq("bp_valid", 64'(host.rdata_valid), 64'd1);
        v = host.rdata; p = pulse_cnt;
        check_eq("bp_value", 64'(v), 64'(dflt({10'd28, 22'd2})));
        ok = 1;
        repeat (10) begin
            step();
            if (host.rdata !== v || !host.rdata_valid || pl_clk) ok = 0;
        end
        check_eq("bp_stable", 64'(ok), 64'd1);
        check_eq("bp_no_strobe", 64'(pulse_cnt - p), 64'd0);
        host.rdata_ready = 1; cnt = 0;
        while (done_cnt == d0 && cnt < 50) begin step(); cnt++; end
        host.rdata_ready = 0;
        check_eq("bp_done", 64'(done_cnt - d0), 64'd1);
        check_eq("bp_strobes", 64'(pulse_cnt - p), 64'd1);
        step();

        // Gapped write stream.
        wq = {};
        for (int i = 0; i < 5; i++) wq.push_back(36'({$urandom(), $urandom()}));
        run_cmd(1'b1, 10'd31, 22'd3, 4, 2'b11, 5, 0, -1, 1'b0);

        // Row wrap keeps the column.
        wq = {36'hA_5A5A_5A5A, 36'h5_A5A5_A5A5};
        run_cmd(1'b1, 10'd30, 22'h3F_FFFF, 1, 2'b11, 0, 0, -1, 1'b0);
        run_cmd(1'b0, 10'd30, 22'h3F_FFFF, 1, 2'b00, 0, 2, -1, 1'b0);

        // Reset during the strobe of the second word.
        wq = {36'h1_1111_1111, 36'h2_2222_2222, 36'h3_3333_3333, 36'h4_4444_4444};
        d0 = done_cnt;
        run_cmd(1'b1, 10'd29, 22'd0, 3, 2'b11, 0, 0, PPW, 1'b0);
        repeat (4) step();
        check_eq("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check_idle("abort_idle");
        run_cmd(1'b0, 10'd29, 22'd0, 1, 2'b00, 0, 0, -1, 1'b0);

        // Randomized bursts with stalls, backpressure and ignored commands.
        for (int n = 0; n < 24; n++) begin
            wq = {};
            for (int i = 0; i < 6; i++) wq.push_back(36'({$urandom(), $urandom()}));
            run_cmd(1'($urandom), 10'(20 + $urandom_range(0, 7)), 22'($urandom_range(0, 20)),
                    int'($urandom_range(0, 5)), 2'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), -1, 1'b1);
        end

        for (int k = 0; k < 1024; k++) begin
            if (ref_wr[k]) check_eq("mem", 64'({shim_wr[k], shim_mem[k]}), 64'({1'b1, ref_mem[k]}));
        end
        check_eq("double_strobe", 64'(dbl_cnt), 64'd0);
        check_eq("strobe_no_ena", 64'(noena_cnt), 64'd0);
        check_eq("err_clear", 64'(err), 64'd0);

`ifdef BRAM_PL_VERIFY_EN
        corrupt_en = 1'b1;
        corrupt_addr = {10'd18, 22'd1};
        wq = {36'h0_0000_1234, 36'h0_0000_5678};
        run_cmd(1'b1, 10'd18, 22'd0, 1, 2'b01, 0, 0, -1, 1'b0);
        check_eq("verify_lo_only", 64'(err), 64'd0);
        run_cmd(1'b1, 10'd18, 22'd0, 1, 2'b11, 0, 0, -1, 1'b0);
        check_eq("verify_full", 64'(err), 64'd1);
        repeat (3) step();
        check_eq("verify_sticky", 64'(err), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
